// File: rtl/dma_hif_burst_ctrl.sv
// dma_hif_burst_ctrl
// Upstream stage of the AHB master interface. Splits one DMA descriptor into
// INCR bursts of at most MAX_BURST words, drives the dmaHIF* request bus and
// moves data between the local FIFOs and that bus. Completion is reported by a
// one-cycle done pulse carrying sticky error/abort status.

module dma_hif_burst_ctrl #(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16,
  parameter int LVL_W     = 6
) (
  input  logic             macPIClk,
  input  logic             macPIClkHardRst_n,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [31:0]      reqAddr,
  input  logic [LEN_W-1:0] reqLen,
  input  logic             reqWrite,
  input  logic             abort,
  output logic             done,
  output logic             doneErr,
  output logic             doneAborted,
  input  logic [31:0]      wrFifoData,
  input  logic [LVL_W-1:0] wrFifoLevel,
  output logic             wrFifoPop,
  input  logic [LVL_W-1:0] rdFifoFree,
  output logic             rdFifoPush,
  output logic [31:0]      rdFifoData,
  output logic [31:0]      dmaHIFAddressIn,
  output logic             dmaHIFRead,
  output logic             dmaHIFWrite,
  output logic [2:0]       dmaHIFSize,
  output logic [31:0]      dmaHIFWriteDataIn,
  input  logic             dmaHIFReady,
  input  logic             dmaHIFReadDataValid,
  input  logic [31:0]      dmaHIFReadDataOut,
  input  logic             dmaHIFError,
  input  logic             dmaHIFTransComplete
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    BURST,
    WAIT_CMPL,
    DONE
  } stateT;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  stateT            state;
  stateT            stateNext;
  logic [31:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] chunkLen;
  logic [LEN_W-1:0] beatCnt;
  logic [LEN_W-1:0] chunk;
  logic [LVL_W-1:0] avail;
  logic             dirWrite;
  logic             errFlag;
  logic             abortFlag;
  logic             hifRead;
  logic             hifWrite;
  logic             pushQ;
  logic [31:0]      pushData;
  logic             accept;
  logic             beat;
  logic             lastBeat;
  logic             spaceOk;
  logic             endNow;
  logic             unusedAddrBits;

  // Word alignment is forced, so the byte-offset bits of the start address are dropped
  assign unusedAddrBits = ^reqAddr[1:0];

  assign accept   = (state == IDLE) & reqValid;
  assign beat     = (state == BURST) & dmaHIFReady;
  assign lastBeat = beat & (beatCnt == chunkLen - LEN_W'(1));
  assign chunk    = (remaining < MAX_LEN) ? remaining : MAX_LEN;
  assign avail    = dirWrite ? wrFifoLevel : rdFifoFree;
  assign spaceOk  = 32'(avail) >= 32'(chunk);
  // An error or abort arriving together with the completion pulse still ends the descriptor
  assign endNow   = (remaining == '0) | errFlag | dmaHIFError | abortFlag | abort;

  // State register
  always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: reserve FIFO space in CHECK before committing to a burst
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (reqValid) begin
          stateNext = (reqLen == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          stateNext = DONE;
        end else if (spaceOk) begin
          stateNext = BURST;
        end
      end
      BURST: begin
        if (lastBeat) begin
          stateNext = WAIT_CMPL;
        end
      end
      WAIT_CMPL: begin
        if (dmaHIFTransComplete) begin
          stateNext = endNow ? DONE : CHECK;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Descriptor datapath: address, words left and per-chunk beat counting
  always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      addr      <= '0;
      remaining <= '0;
      chunkLen  <= '0;
      beatCnt   <= '0;
      dirWrite  <= 1'b0;
    end else if (accept) begin
      addr      <= {reqAddr[31:2], 2'b00};
      remaining <= reqLen;
      dirWrite  <= reqWrite;
    end else if (beat) begin
      addr      <= addr + 32'd4;
      remaining <= remaining - LEN_W'(1);
      beatCnt   <= beatCnt + LEN_W'(1);
    end else if ((state == CHECK) && (stateNext == BURST)) begin
      chunkLen  <= chunk;
      beatCnt   <= '0;
    end
  end

  // Bus request is held for the whole chunk and drops right after its last beat
  always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      hifRead  <= 1'b0;
      hifWrite <= 1'b0;
    end else begin
      hifRead  <= (stateNext == BURST) & ~dirWrite;
      hifWrite <= (stateNext == BURST) & dirWrite;
    end
  end

  // Sticky error/abort status, cleared while waiting for the next descriptor
  always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      errFlag   <= 1'b0;
      abortFlag <= 1'b0;
    end else if (state == IDLE) begin
      errFlag   <= 1'b0;
      abortFlag <= 1'b0;
    end else begin
      if (dmaHIFError && ((state == BURST) || (state == WAIT_CMPL))) begin
        errFlag <= 1'b1;
      end
      if (abort) begin
        abortFlag <= 1'b1;
      end
    end
  end

  // Read data path: one-cycle registered hand-off into the read FIFO
  always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
    if (!macPIClkHardRst_n) begin
      pushQ    <= 1'b0;
      pushData <= '0;
    end else begin
      pushQ <= dmaHIFReadDataValid;
      if (dmaHIFReadDataValid) begin
        pushData <= dmaHIFReadDataOut;
      end
    end
  end

  assign reqReady          = (state == IDLE);
  assign done              = (state == DONE);
  assign doneErr           = (state == DONE) & errFlag;
  assign doneAborted       = (state == DONE) & abortFlag;
  assign wrFifoPop         = beat & dirWrite;
  assign rdFifoPush        = pushQ;
  assign rdFifoData        = pushData;
  assign dmaHIFAddressIn   = addr;
  assign dmaHIFRead        = hifRead;
  assign dmaHIFWrite       = hifWrite;
  assign dmaHIFSize        = 3'b010;
  assign dmaHIFWriteDataIn = wrFifoData;

endmodule

// File: tb/tb_dma_hif_burst_ctrl.sv
// tb_dma_hif_burst_ctrl
// Randomized bench for dma_hif_burst_ctrl: a bus-slave process answers the
// dmaHIF* requests, and a transaction-level model (expected address stream,
// words left, chunk sizes, sticky status) is compared against the DUT every cycle.

module tb_dma_hif_burst_ctrl;

  localparam int MAX_BURST = 16;
  localparam int LEN_W     = 16;
  localparam int LVL_W     = 6;

  logic             macPIClk;
  logic             macPIClkHardRst_n;
  logic             reqValid;
  logic             reqReady;
  logic [31:0]      reqAddr;
  logic [LEN_W-1:0] reqLen;
  logic             reqWrite;
  logic             abort;
  logic             done;
  logic             doneErr;
  logic             doneAborted;
  logic [31:0]      wrFifoData;
  logic [LVL_W-1:0] wrFifoLevel;
  logic             wrFifoPop;
  logic [LVL_W-1:0] rdFifoFree;
  logic             rdFifoPush;
  logic [31:0]      rdFifoData;
  logic [31:0]      dmaHIFAddressIn;
  logic             dmaHIFRead;
  logic             dmaHIFWrite;
  logic [2:0]       dmaHIFSize;
  logic [31:0]      dmaHIFWriteDataIn;
  logic             dmaHIFReady;
  logic             dmaHIFReadDataValid;
  logic [31:0]      dmaHIFReadDataOut;
  logic             dmaHIFError;
  logic             dmaHIFTransComplete;

  dma_hif_burst_ctrl #(
    .MAX_BURST(MAX_BURST),
    .LEN_W(LEN_W),
    .LVL_W(LVL_W)
  ) dut (
    .macPIClk(macPIClk),
    .macPIClkHardRst_n(macPIClkHardRst_n),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqAddr(reqAddr),
    .reqLen(reqLen),
    .reqWrite(reqWrite),
    .abort(abort),
    .done(done),
    .doneErr(doneErr),
    .doneAborted(doneAborted),
    .wrFifoData(wrFifoData),
    .wrFifoLevel(wrFifoLevel),
    .wrFifoPop(wrFifoPop),
    .rdFifoFree(rdFifoFree),
    .rdFifoPush(rdFifoPush),
    .rdFifoData(rdFifoData),
    .dmaHIFAddressIn(dmaHIFAddressIn),
    .dmaHIFRead(dmaHIFRead),
    .dmaHIFWrite(dmaHIFWrite),
    .dmaHIFSize(dmaHIFSize),
    .dmaHIFWriteDataIn(dmaHIFWriteDataIn),
    .dmaHIFReady(dmaHIFReady),
    .dmaHIFReadDataValid(dmaHIFReadDataValid),
    .dmaHIFReadDataOut(dmaHIFReadDataOut),
    .dmaHIFError(dmaHIFError),
    .dmaHIFTransComplete(dmaHIFTransComplete)
  );

  int total;
  int bad;

  // Knobs set by the main sequence, read by the bus slave
  int descSeq;
  int errAt;
  int abortAt;
  int readyPct;
  int abortKick;

  // Transaction model and per-descriptor logs, owned by the compare process
  bit          mBusy;
  bit          mDir;
  bit          mErr;
  bit          mAbort;
  logic [31:0] mAddr;
  int          mRem;
  int          mChunkExp;
  int          mChunkBeats;
  bit          prevReq;
  int          prevLevel;
  bit          prevValid;
  logic [31:0] prevData;
  bit          curReq;
  logic [31:0] addrLog [64];
  int          addrCnt;
  int          burstLog [16];
  int          burstCnt;
  int          burstStarts;
  int          pushCnt;
  int          popCnt;
  int          doneCnt;
  bit          lastErr;
  bit          lastAborted;

  // Bus-slave private state
  int          sSeq;
  int          sBeats;
  bit          sErrDone;
  bit          sAbortDone;
  int          sAbortKick;
  bit          sPrevReq;
  bit          sPrevRead;
  bit          sBeat;
  bit          sCurReq;
  int          cmplCnt;

  initial macPIClk = 1'b0;
  always #5 macPIClk = ~macPIClk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare process: every cycle, check the DUT against the transaction model
  always @(negedge macPIClk) begin
    if (!macPIClkHardRst_n) begin
      mBusy     = 1'b0;
      prevReq   = 1'b0;
      prevValid = 1'b0;
    end else begin
      curReq = dmaHIFRead | dmaHIFWrite;
      checkOutput("hifSize", 32'(dmaHIFSize), 32'd2);
      checkOutput("writeDataPass", dmaHIFWriteDataIn, wrFifoData);
      checkOutput("reqReady", 32'(reqReady), 32'(!mBusy));
      checkOutput("rdPush", 32'(rdFifoPush), 32'(prevValid));
      if (prevValid && rdFifoPush) checkOutput("rdData", rdFifoData, prevData);
      if (rdFifoPush) pushCnt++;
      checkOutput("wrPop", 32'(wrFifoPop), 32'(dmaHIFWrite & dmaHIFReady));
      if (wrFifoPop) popCnt++;
      if (curReq && !prevReq) begin
        burstStarts++;
        checkOutput("burstWhileBusy", 32'(mBusy), 32'd1);
        checkOutput("burstAfterStop", 32'(mErr | mAbort), 32'd0);
        mChunkExp = (mRem < MAX_BURST) ? mRem : MAX_BURST;
        checkOutput("spaceReserved", 32'(prevLevel >= mChunkExp), 32'd1);
        mChunkBeats = 0;
      end
      if (curReq) begin
        checkOutput("burstDir", {30'd0, dmaHIFRead, dmaHIFWrite}, mDir ? 32'd1 : 32'd2);
        if (dmaHIFReady) begin
          checkOutput("beatAddr", dmaHIFAddressIn, mAddr);
          if (addrCnt < 64) addrLog[addrCnt] = dmaHIFAddressIn;
          addrCnt++;
          mAddr = mAddr + 32'd4;
          mRem--;
          mChunkBeats++;
          checkOutput("beatWithinChunk", 32'(mChunkBeats <= mChunkExp), 32'd1);
        end
        if (dmaHIFError) mErr = 1'b1;
      end
      if (!curReq && prevReq) begin
        checkOutput("chunkBeats", 32'(mChunkBeats), 32'(mChunkExp));
        if (burstCnt < 16) burstLog[burstCnt] = mChunkBeats;
        burstCnt++;
      end
      if (done) begin
        checkOutput("doneWhenBusy", 32'(mBusy), 32'd1);
        checkOutput("doneNoRequest", 32'(curReq), 32'd0);
        checkOutput("doneErr", 32'(doneErr), 32'(mErr));
        checkOutput("doneAborted", 32'(doneAborted), 32'(mAbort));
        if (!mErr && !mAbort) checkOutput("allWordsMoved", 32'(mRem), 32'd0);
        doneCnt++;
        lastErr     = doneErr;
        lastAborted = doneAborted;
        mBusy       = 1'b0;
      end else begin
        checkOutput("statusOutsideDone", {30'd0, doneErr, doneAborted}, 32'd0);
      end
      if (abort && mBusy) mAbort = 1'b1;
      if (reqValid && reqReady) begin
        mBusy       = 1'b1;
        mDir        = reqWrite;
        mAddr       = {reqAddr[31:2], 2'b00};
        mRem        = int'(reqLen);
        mErr        = 1'b0;
        mAbort      = 1'b0;
        mChunkBeats = 0;
        mChunkExp   = 0;
        addrCnt     = 0;
        burstCnt    = 0;
        burstStarts = 0;
        pushCnt     = 0;
        popCnt      = 0;
        doneCnt     = 0;
      end
      prevReq   = curReq;
      prevLevel = mDir ? int'(wrFifoLevel) : int'(rdFifoFree);
      prevValid = dmaHIFReadDataValid;
      prevData  = dmaHIFReadDataOut;
    end
  end

  // Bus slave: random ready, read data one cycle after each accepted read beat,
  // completion pulse a few cycles after the request drops, injected error/abort
  initial begin
    dmaHIFReady         = 1'b0;
    dmaHIFReadDataValid = 1'b0;
    dmaHIFReadDataOut   = '0;
    dmaHIFError         = 1'b0;
    dmaHIFTransComplete = 1'b0;
    abort               = 1'b0;
    wrFifoData          = '0;
    sSeq = 0; sBeats = 0; sErrDone = 0; sAbortDone = 0; sAbortKick = 0;
    sPrevReq = 0; sPrevRead = 0; cmplCnt = 0;
    forever begin
      @(posedge macPIClk);
      #2;
      if (!macPIClkHardRst_n) begin
        dmaHIFReady         = 1'b0;
        dmaHIFReadDataValid = 1'b0;
        dmaHIFError         = 1'b0;
        dmaHIFTransComplete = 1'b0;
        abort               = 1'b0;
        sPrevReq            = 1'b0;
        sPrevRead           = 1'b0;
        cmplCnt             = 0;
        sAbortKick          = abortKick;
      end else begin
        sBeat = sPrevReq & dmaHIFReady;
        if (sSeq != descSeq) begin
          sSeq = descSeq; sBeats = 0; sErrDone = 0; sAbortDone = 0;
        end
        if (sBeat) sBeats++;
        dmaHIFReadDataValid = sBeat & sPrevRead;
        dmaHIFReadDataOut   = $urandom;
        dmaHIFTransComplete = 1'b0;
        if (cmplCnt != 0) begin
          cmplCnt--;
          if (cmplCnt == 0) dmaHIFTransComplete = 1'b1;
        end
        sCurReq = dmaHIFRead | dmaHIFWrite;
        if (sPrevReq && !sCurReq) cmplCnt = $urandom_range(4, 2);
        dmaHIFReady = ($urandom_range(99, 0) < readyPct);
        dmaHIFError = 1'b0;
        abort       = 1'b0;
        if (sCurReq && !sErrDone && (sBeats == errAt)) begin
          dmaHIFError = 1'b1;
          sErrDone    = 1'b1;
        end
        if (sCurReq && !sAbortDone && (sBeats == abortAt)) begin
          abort      = 1'b1;
          sAbortDone = 1'b1;
        end
        if (abortKick != sAbortKick) begin
          sAbortKick = abortKick;
          abort      = 1'b1;
        end
        wrFifoData = $urandom;
        sPrevReq   = sCurReq;
        sPrevRead  = dmaHIFRead;
      end
    end
  end

  // Present one descriptor and hold it until accepted
  task automatic applyStimulus(input logic [31:0] a, input int len, input bit wr);
    int waited;
    @(posedge macPIClk);
    #2;
    descSeq++;
    reqAddr  = a;
    reqLen   = LEN_W'(len);
    reqWrite = wr;
    reqValid = 1'b1;
    waited   = 0;
    while (!reqReady && waited < 200) begin
      @(posedge macPIClk);
      #2;
      waited++;
    end
    if (!reqReady) checkOutput("acceptTimeout", 32'(reqReady), 32'd1);
    @(posedge macPIClk);
    #2;
    reqValid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (doneCnt == 0 && n < budget) begin
      @(negedge macPIClk);
      #1;
      n++;
    end
    if (doneCnt == 0) begin
      checkOutput("doneTimeout", 32'(doneCnt), 32'd1);
      hardReset();
    end
  endtask

  task automatic hardReset();
    @(posedge macPIClk);
    #2;
    macPIClkHardRst_n = 1'b0;
    repeat (3) @(posedge macPIClk);
    #2;
    macPIClkHardRst_n = 1'b1;
  endtask

  // Safety net in case some wait escapes its own bound
  initial begin
    #5_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  // Main sequence: directed cases pinning the model, then randomized descriptors
  initial begin
    total = 0; bad = 0; descSeq = 0; errAt = -1; abortAt = -1; readyPct = 100; abortKick = 0;
    doneCnt = 0; addrCnt = 0; burstCnt = 0; burstStarts = 0; pushCnt = 0; popCnt = 0;
    macPIClkHardRst_n = 1'b0;
    reqValid = 1'b0; reqAddr = '0; reqLen = '0; reqWrite = 1'b0;
    wrFifoLevel = '0; rdFifoFree = '0;
    repeat (3) @(posedge macPIClk);
    #1;
    checkOutput("rstReqReady", 32'(reqReady), 32'd1);
    checkOutput("rstDone", {29'd0, done, doneErr, doneAborted}, 32'd0);
    checkOutput("rstRequest", {30'd0, dmaHIFRead, dmaHIFWrite}, 32'd0);
    checkOutput("rstAddr", dmaHIFAddressIn, 32'd0);
    checkOutput("rstFifo", {30'd0, wrFifoPop, rdFifoPush}, 32'd0);
    checkOutput("rstSize", 32'(dmaHIFSize), 32'd2);
    @(posedge macPIClk);
    #2;
    macPIClkHardRst_n = 1'b1;

    // Single short read burst
    $display("[TB] read len=4 at 0x1000");
    rdFifoFree = 6'd8; wrFifoLevel = 6'd0;
    applyStimulus(32'h0000_1000, 4, 1'b0);
    waitDone(200);
    checkOutput("s1Beats", 32'(addrCnt), 32'd4);
    checkOutput("s1Addr0", addrLog[0], 32'h0000_1000);
    checkOutput("s1Addr1", addrLog[1], 32'h0000_1004);
    checkOutput("s1Addr2", addrLog[2], 32'h0000_1008);
    checkOutput("s1Addr3", addrLog[3], 32'h0000_100C);
    checkOutput("s1Pushes", 32'(pushCnt), 32'd4);
    checkOutput("s1Bursts", 32'(burstCnt), 32'd1);
    checkOutput("s1Err", 32'(lastErr), 32'd0);

    // Long write split into 16/16/8
    $display("[TB] write len=40 at 0x2000");
    wrFifoLevel = 6'd63; readyPct = 70;
    applyStimulus(32'h0000_2000, 40, 1'b1);
    waitDone(1000);
    repeat (3) @(posedge macPIClk);
    #1;
    checkOutput("s2Bursts", 32'(burstCnt), 32'd3);
    checkOutput("s2Burst0", 32'(burstLog[0]), 32'd16);
    checkOutput("s2Burst1", 32'(burstLog[1]), 32'd16);
    checkOutput("s2Burst2", 32'(burstLog[2]), 32'd8);
    checkOutput("s2Pops", 32'(popCnt), 32'd40);
    checkOutput("s2FinalAddr", dmaHIFAddressIn, 32'h0000_20A0);
    checkOutput("s2DoneOnce", 32'(doneCnt), 32'd1);

    // Write stalls until the write FIFO holds the whole chunk
    $display("[TB] write len=8 with level 5 then 8");
    wrFifoLevel = 6'd5; readyPct = 100;
    applyStimulus(32'h0000_3000, 8, 1'b1);
    repeat (20) @(posedge macPIClk);
    checkOutput("s3NoBurstYet", 32'(burstStarts), 32'd0);
    checkOutput("s3NotDone", 32'(doneCnt), 32'd0);
    #2;
    wrFifoLevel = 6'd8;
    waitDone(200);
    checkOutput("s3Bursts", 32'(burstCnt), 32'd1);
    checkOutput("s3Burst0", 32'(burstLog[0]), 32'd8);
    checkOutput("s3Pops", 32'(popCnt), 32'd8);

    // Error on the third beat of a 32-word read
    $display("[TB] read len=32 with error on beat 3");
    rdFifoFree = 6'd63; wrFifoLevel = 6'd63; errAt = 2;
    applyStimulus(32'h0000_4000, 32, 1'b0);
    waitDone(500);
    checkOutput("s4Err", 32'(lastErr), 32'd1);
    checkOutput("s4Aborted", 32'(lastAborted), 32'd0);
    checkOutput("s4Bursts", 32'(burstCnt), 32'd1);
    checkOutput("s4Burst0", 32'(burstLog[0]), 32'd16);
    checkOutput("s4Beats", 32'(addrCnt), 32'd16);
    errAt = -1;

    // Zero-length descriptor finishes the cycle after acceptance
    $display("[TB] zero-length descriptor");
    applyStimulus(32'h0000_5000, 0, 1'b0);
    @(negedge macPIClk);
    #1;
    checkOutput("s5ZeroDone", 32'(done), 32'd1);
    checkOutput("s5ZeroErr", 32'(doneErr), 32'd0);
    repeat (2) @(posedge macPIClk);
    checkOutput("s5ZeroNoBurst", 32'(burstStarts), 32'd0);

    // Abort while waiting for FIFO space
    $display("[TB] abort while waiting for space");
    wrFifoLevel = 6'd2;
    applyStimulus(32'h0000_6000, 8, 1'b1);
    repeat (5) @(posedge macPIClk);
    abortKick++;
    waitDone(100);
    checkOutput("s5Aborted", 32'(lastAborted), 32'd1);
    checkOutput("s5AbortErr", 32'(lastErr), 32'd0);
    checkOutput("s5AbortNoBurst", 32'(burstStarts), 32'd0);
    wrFifoLevel = 6'd63;

    // Address wrap at the top of the 32-bit space
    $display("[TB] read wrapping past 0xFFFFFFFC");
    applyStimulus(32'hFFFF_FFF8, 4, 1'b0);
    waitDone(200);
    checkOutput("s6Wrap0", addrLog[0], 32'hFFFF_FFF8);
    checkOutput("s6Wrap1", addrLog[1], 32'hFFFF_FFFC);
    checkOutput("s6Wrap2", addrLog[2], 32'h0000_0000);
    checkOutput("s6Wrap3", addrLog[3], 32'h0000_0004);

    // Reset in the middle of a burst clears outputs immediately
    $display("[TB] reset during a read burst");
    applyStimulus(32'h0000_7000, 16, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge macPIClk);
      #1;
      if (addrCnt >= 3) break;
    end
    checkOutput("s6MidBurst", 32'(addrCnt >= 3), 32'd1);
    @(posedge macPIClk);
    #2;
    macPIClkHardRst_n = 1'b0;
    #1;
    checkOutput("s6RstRequest", {30'd0, dmaHIFRead, dmaHIFWrite}, 32'd0);
    checkOutput("s6RstAddr", dmaHIFAddressIn, 32'd0);
    checkOutput("s6RstFifo", {30'd0, wrFifoPop, rdFifoPush}, 32'd0);
    checkOutput("s6RstRdData", rdFifoData, 32'd0);
    checkOutput("s6RstDone", 32'(done), 32'd0);
    checkOutput("s6RstReady", 32'(reqReady), 32'd1);
    repeat (2) @(posedge macPIClk);
    #2;
    macPIClkHardRst_n = 1'b1;

    // Randomized descriptors with occasional error/abort injection
    $display("[TB] randomized descriptors");
    for (int t = 0; t < 30; t++) begin
      int len;
      bit wr;
      len         = $urandom_range(50, 0);
      wr          = $urandom_range(1, 0);
      readyPct    = $urandom_range(100, 30);
      wrFifoLevel = LVL_W'($urandom_range(63, 16));
      rdFifoFree  = LVL_W'($urandom_range(63, 16));
      errAt       = ($urandom_range(4, 0) == 0) ? $urandom_range(len, 0) : -1;
      abortAt     = ($urandom_range(4, 0) == 0) ? $urandom_range(len, 0) : -1;
      applyStimulus($urandom, len, wr);
      waitDone(3000);
      repeat ($urandom_range(3, 1)) @(posedge macPIClk);
    end

    repeat (3) @(posedge macPIClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
